// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the clk_en_gen clock-enable generator.
package clk_gen_pkg;

  typedef enum logic [1:0] {WAIT, LOCKED, RELOCK} lock_state_e;

  localparam int unsigned DIV_MIN = 2;

  // High-phase length of a divided square wave: ceil(div/2).
  function automatic logic [31:0] hi_len(input logic [31:0] div);
    return (div + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active divisor, pending update, enable/square-wave regs.
// Optional CLK_EN_GEN_SYNC_EN adds sync_i for phase alignment.
module clk_div_ch
  import clk_gen_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
`ifdef CLK_EN_GEN_SYNC_EN
  input  logic             sync_i,
`endif
  input  logic             set_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             clk_en_o,
  output logic             clk_out_o,
  output logic             pend_o,
  output logic             pend_nxt_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] ndiv_q, ndiv_d;
  logic [DIV_W-1:0] thr;
  logic             pend_q, pend_d;
  logic             en_q, en_d;
  logic             out_q, out_d;
  logic             tc;

  always_comb begin
    tc     = (cnt_q == div_q - DIV_W'(1));
    cnt_d  = tc ? '0 : cnt_q + DIV_W'(1);
    div_d  = div_q;
    ndiv_d = ndiv_q;
    pend_d = pend_q;
    en_d   = tc;
    // A pending divisor only takes over at a period boundary, so no short pulse appears.
    if (tc && pend_q) begin
      div_d  = ndiv_q;
      pend_d = 1'b0;
    end
`ifdef CLK_EN_GEN_SYNC_EN
    if (sync_i) begin
      cnt_d  = '0;
      en_d   = 1'b0;
      div_d  = pend_q ? ndiv_q : div_q;
      pend_d = 1'b0;
    end
`endif
    if (set_i) begin
      pend_d = 1'b1;
      ndiv_d = div_i;
    end
    // thr >= 1 for any legal divisor, so a zeroed counter always yields a low output.
    thr   = div_d - DIV_W'(hi_len(32'(div_d)));
    out_d = (cnt_d >= thr);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      div_q  <= DIV_W'(DEFAULT_DIV);
      ndiv_q <= DIV_W'(DEFAULT_DIV);
      pend_q <= 1'b0;
      en_q   <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      ndiv_q <= ndiv_d;
      pend_q <= pend_d;
      en_q   <= en_d;
      out_q  <= out_d;
    end
  end

  assign clk_en_o   = en_q;
  assign clk_out_o  = out_q;
  assign pend_o     = pend_q;
  assign pend_nxt_o = pend_d;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: cfg decode, error pulse and lock FSM over clk_div_ch.
// Define CLK_EN_GEN_SYNC_EN to add the sync_i phase-alignment input.
module clk_en_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned  NUM_CH      = 2,
  parameter int unsigned  DIV_W       = 8,
  parameter int unsigned  DEFAULT_DIV = 4,
  parameter int unsigned  LOCK_CYCLES = 256,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
`ifdef CLK_EN_GEN_SYNC_EN
  input  logic              sync_i,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int unsigned LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [NUM_CH-1:0] pend, pend_nxt, set;
  logic              accept, req_ok, legal;
  logic              err_q, locked_q;
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
  lock_state_e       state_q, state_d;

  // Out-of-range channels report ready so the request can be accepted and flagged.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(cfg_ch) == i) cfg_ready = ~pend[i];
    end
    accept = cfg_valid && cfg_ready;
    req_ok = (32'(cfg_ch) < NUM_CH) && (cfg_div >= DIV_W'(DIV_MIN));
    legal  = accept && req_ok;
    set    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(cfg_ch) == i) set[i] = legal;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in     (clk_in),
      .reset_n    (reset_n),
`ifdef CLK_EN_GEN_SYNC_EN
      .sync_i     (sync_i),
`endif
      .set_i      (set[g]),
      .div_i      (cfg_div),
      .clk_en_o   (clk_en[g]),
      .clk_out_o  (clk_out[g]),
      .pend_o     (pend[g]),
      .pend_nxt_o (pend_nxt[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      WAIT: begin
        if (lock_cnt_q == LC_W'(LOCK_CYCLES - 1)) begin
          if (pend_nxt == '0) state_d = LOCKED;
        end else begin
          lock_cnt_d = lock_cnt_q + LC_W'(1);
        end
      end
      LOCKED:  if (legal) state_d = RELOCK;
      RELOCK:  if (pend_nxt == '0) state_d = LOCKED;
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= (state_d == LOCKED);
      err_q      <= accept && !req_ok;
    end
  end

  assign locked  = locked_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen (NUM_CH=3 so an out-of-range channel is encodable).
module tb_clk_en_gen;

  logic       clk_in    = 1'b0;
  logic       reset_n   = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch    = '0;
  logic [7:0] cfg_div   = '0;
  logic       cfg_ready, cfg_err, locked;
  logic [2:0] clk_en, clk_out;
`ifdef CLK_EN_GEN_SYNC_EN
  logic       sync_i    = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  clk_en_gen #(
    .NUM_CH      (3),
    .DIV_W       (8),
    .DEFAULT_DIV (4),
    .LOCK_CYCLES (256)
  ) dut (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
`ifdef CLK_EN_GEN_SYNC_EN
    .sync_i    (sync_i),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .clk_en    (clk_en),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  typedef struct {
    int         e;
    logic [2:0] en;
    logic [2:0] out;
    logic       lk;
    logic       err;
    logic       v;
    logic [1:0] ch;
    logic [7:0] div;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   ecnt  = 0;

  task automatic add(input int e, input logic [2:0] en, input logic [2:0] out,
                     input logic lk, input logic err, input logic v,
                     input logic [1:0] ch, input logic [7:0] div, input logic rdy);
    vec_t r;
    r.e = e; r.en = en; r.out = out; r.lk = lk; r.err = err;
    r.v = v; r.ch = ch; r.div = div; r.rdy = rdy;
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    ecnt++;
  endtask

  task automatic to_edge(input int n);
    while (ecnt < n) step();
  endtask

  initial begin
    // edge, en{2,1,0}, out{2,1,0}, locked, err, then inputs driven for the next edge, ready
    add(1,   3'b000, 3'b000, 0, 0, 0, 0, 0, 1);
    add(2,   3'b000, 3'b111, 0, 0, 0, 0, 0, 1);
    add(3,   3'b000, 3'b111, 0, 0, 0, 0, 0, 1);
    add(4,   3'b111, 3'b000, 0, 0, 0, 0, 0, 1);
    add(5,   3'b000, 3'b000, 0, 0, 0, 0, 0, 1);
    add(6,   3'b000, 3'b111, 0, 0, 0, 0, 0, 1);
    add(8,   3'b111, 3'b000, 0, 0, 0, 0, 0, 1);
    add(12,  3'b111, 3'b000, 0, 0, 0, 0, 0, 1);
    add(255, 3'b000, 3'b111, 0, 0, 0, 0, 0, 1);
    add(256, 3'b111, 3'b000, 1, 0, 0, 0, 0, 1);
    add(258, 3'b000, 3'b111, 1, 0, 1, 1, 5, 1);
    add(259, 3'b000, 3'b111, 0, 0, 0, 1, 0, 0);
    add(260, 3'b111, 3'b000, 1, 0, 0, 1, 0, 1);
    add(261, 3'b000, 3'b000, 1, 0, 0, 0, 0, 1);
    add(262, 3'b000, 3'b111, 1, 0, 0, 0, 0, 1);
    add(263, 3'b000, 3'b111, 1, 0, 0, 0, 0, 1);
    add(264, 3'b101, 3'b010, 1, 0, 0, 0, 0, 1);
    add(265, 3'b010, 3'b000, 1, 0, 0, 0, 0, 1);
    add(266, 3'b000, 3'b101, 1, 0, 1, 0, 1, 1);
    add(267, 3'b000, 3'b111, 1, 1, 1, 3, 6, 1);
    add(268, 3'b101, 3'b010, 1, 1, 0, 0, 0, 1);
    add(269, 3'b000, 3'b010, 1, 0, 0, 0, 0, 1);
    add(270, 3'b010, 3'b101, 1, 0, 0, 0, 0, 1);
    add(272, 3'b101, 3'b010, 1, 0, 0, 0, 0, 1);
    add(273, 3'b000, 3'b010, 1, 0, 1, 0, 3, 1);
    add(274, 3'b000, 3'b111, 0, 0, 1, 0, 6, 0);
    add(275, 3'b010, 3'b101, 0, 0, 1, 0, 6, 0);
    add(276, 3'b101, 3'b000, 1, 0, 1, 0, 6, 1);
    add(277, 3'b000, 3'b011, 0, 0, 0, 0, 0, 0);
    add(278, 3'b000, 3'b111, 0, 0, 0, 0, 0, 0);
    add(279, 3'b001, 3'b110, 1, 0, 0, 0, 0, 1);
    add(280, 3'b110, 3'b000, 1, 0, 0, 0, 0, 1);
    add(284, 3'b100, 3'b011, 1, 0, 1, 0, 3, 1);
    add(285, 3'b011, 3'b000, 0, 0, 0, 0, 0, 0);
    add(290, 3'b010, 3'b101, 0, 0, 0, 0, 0, 0);
    add(291, 3'b001, 3'b100, 1, 0, 0, 0, 0, 1);
    add(292, 3'b100, 3'b011, 1, 0, 0, 0, 0, 1);
    add(294, 3'b001, 3'b110, 1, 0, 1, 1, 4, 1);
    add(295, 3'b010, 3'b101, 0, 0, 1, 2, 5, 1);
    add(296, 3'b100, 3'b001, 0, 0, 0, 0, 0, 1);
    add(299, 3'b000, 3'b111, 0, 0, 0, 0, 0, 1);
    add(300, 3'b111, 3'b000, 1, 0, 0, 0, 0, 1);
    add(302, 3'b000, 3'b111, 1, 0, 0, 0, 0, 1);
    add(304, 3'b010, 3'b101, 1, 0, 0, 0, 0, 1);
    add(305, 3'b100, 3'b001, 1, 0, 1, 1, 7, 1);

    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_en",  clk_en,    3'b000);
    chk("rst_out", clk_out,   3'b000);
    chk("rst_lk",  locked,    1'b0);
    chk("rst_err", cfg_err,   1'b0);
    chk("rst_rdy", cfg_ready, 1'b1);
    reset_n = 1'b1;
    ecnt    = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      to_edge(tbl[i].e);
      chk($sformatf("en@%0d",  tbl[i].e), clk_en,  tbl[i].en);
      chk($sformatf("out@%0d", tbl[i].e), clk_out, tbl[i].out);
      chk($sformatf("lk@%0d",  tbl[i].e), locked,  tbl[i].lk);
      chk($sformatf("err@%0d", tbl[i].e), cfg_err, tbl[i].err);
      cfg_valid = tbl[i].v;
      cfg_ch    = tbl[i].ch;
      cfg_div   = tbl[i].div;
      #1;
      chk($sformatf("rdy@%0d", tbl[i].e), cfg_ready, tbl[i].rdy);
    end

    // Reset in the middle of a pending ch1 update: everything drops, the update is lost.
    step();
    chk("lk_acc306", locked, 1'b0);
    chk("en_306",    clk_en, 3'b001);
    cfg_valid = 1'b0;
    cfg_ch    = 2'd1;
    #1;
    chk("rdy_pend", cfg_ready, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_en",  clk_en,    3'b000);
    chk("arst_out", clk_out,   3'b000);
    chk("arst_lk",  locked,    1'b0);
    chk("arst_err", cfg_err,   1'b0);
    chk("arst_rdy", cfg_ready, 1'b1);
    repeat (2) @(posedge clk_in);
    #1;
    reset_n = 1'b1;
    cfg_ch  = 2'd0;
    ecnt    = 0;
    to_edge(2);
    chk("r2_out@2", clk_out, 3'b111);
    to_edge(4);
    chk("r2_en@4",  clk_en,  3'b111);
    chk("r2_lk@4",  locked,  1'b0);
    to_edge(8);
    chk("r2_en@8",  clk_en,  3'b111);

`ifdef CLK_EN_GEN_SYNC_EN
    cfg_valid = 1'b1;
    cfg_ch    = 2'd1;
    cfg_div   = 8'd8;
    to_edge(9);
    cfg_valid = 1'b0;
    sync_i    = 1'b1;
    to_edge(10);
    sync_i    = 1'b0;
    chk("sy_en@10",  clk_en,  3'b000);
    chk("sy_out@10", clk_out, 3'b000);
    chk("sy_lk@10",  locked,  1'b0);
    to_edge(12);
    chk("sy_out@12", clk_out, 3'b101);
    to_edge(14);
    chk("sy_en@14",  clk_en,  3'b101);
    to_edge(18);
    chk("sy_en@18",  clk_en,  3'b111);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
